// File: rtl/fetch_stage.sv
// fetch_stage: PC owner and instruction fetch front end with a 2-entry decode queue
module fetch_stage #(
  parameter int PC_WIDTH = 32,
  parameter int IWIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                f_clk,
  input  logic                f_rst,
  input  logic                f_i_ce,
  output logic                f_o_imem_req,
  output logic [PC_WIDTH-1:0] f_o_imem_addr,
  input  logic [IWIDTH-1:0]   f_i_imem_data,
  input  logic                f_i_redirect,
  input  logic [PC_WIDTH-1:0] f_i_redirect_pc,
  output logic                f_o_valid,
  output logic [IWIDTH-1:0]   f_o_instr,
  output logic [PC_WIDTH-1:0] f_o_pc,
  output logic [PC_WIDTH-1:0] f_o_pc_plus4,
  input  logic                f_i_ready
);
  logic [PC_WIDTH-1:0] pc, inflight_pc;
  logic                inflight, pop, push;
  logic [1:0]          count, wr_idx;
  logic [2:0]          credit;
  logic [IWIDTH-1:0]   q_instr [2];
  logic [PC_WIDTH-1:0] q_pc [2];
  assign f_o_valid = count != 2'd0;
  assign pop = f_o_valid & f_i_ready;
  assign push = inflight & ~f_i_redirect;
  assign wr_idx = count - {1'b0, pop};
  assign credit = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
  // gated by reset so every output reads 0 while reset is held
  assign f_o_imem_req = f_rst & f_i_ce & ~f_i_redirect & (credit < 3'd2);
  assign f_o_imem_addr = f_rst ? pc : '0;
  assign f_o_instr = f_o_valid ? q_instr[0] : '0;
  assign f_o_pc = f_o_valid ? q_pc[0] : '0;
  assign f_o_pc_plus4 = f_o_valid ? q_pc[0] + PC_WIDTH'(4) : '0;
  always_ff @(posedge f_clk or negedge f_rst) begin
    if (!f_rst) begin
      pc <= RESET_PC;
      count <= 2'd0;
      inflight <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight <= f_o_imem_req;
      if (f_o_imem_req) inflight_pc <= pc;
      pc <= f_i_redirect ? f_i_redirect_pc : f_o_imem_req ? pc + PC_WIDTH'(4) : pc;
      count <= f_i_redirect ? 2'd0 : count + {1'b0, push} - {1'b0, pop};
    end
  end
  // slot 0 is the head; a pop shifts, and a push lands in the first free slot after the pop
  always_ff @(posedge f_clk) begin
    if (pop) begin
      q_instr[0] <= q_instr[1];
      q_pc[0] <= q_pc[1];
    end
    if (push) begin
      q_instr[wr_idx[0]] <= f_i_imem_data;
      q_pc[wr_idx[0]] <= inflight_pc;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboarded bench for fetch_stage with a one-cycle-latency ROM model
module tb_fetch_stage;
  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
  logic        f_clk = 1'b0, f_rst = 1'b0, f_i_ce = 1'b0, f_i_redirect = 1'b0, f_i_ready = 1'b0;
  logic [31:0] f_i_redirect_pc = '0, f_i_imem_data = '0;
  logic        f_o_imem_req, f_o_valid;
  logic [31:0] f_o_imem_addr, f_o_instr, f_o_pc, f_o_pc_plus4;
  logic [31:0] exp_q [$];
  logic [31:0] e_pc, h_pc, h_in, h_addr;
  int          n_chk = 0, n_fail = 0, n_pop = 0;

  fetch_stage #(.PC_WIDTH(32), .IWIDTH(32), .RESET_PC(RST_PC)) dut (
    .f_clk(f_clk), .f_rst(f_rst), .f_i_ce(f_i_ce),
    .f_o_imem_req(f_o_imem_req), .f_o_imem_addr(f_o_imem_addr), .f_i_imem_data(f_i_imem_data),
    .f_i_redirect(f_i_redirect), .f_i_redirect_pc(f_i_redirect_pc),
    .f_o_valid(f_o_valid), .f_o_instr(f_o_instr), .f_o_pc(f_o_pc), .f_o_pc_plus4(f_o_pc_plus4),
    .f_i_ready(f_i_ready)
  );

  always #5 f_clk = ~f_clk;

  // ROM: word at address a is 0x1000_0000 + a, returned the cycle after the request
  always @(posedge f_clk) f_i_imem_data <= f_o_imem_req ? 32'h1000_0000 + f_o_imem_addr : 32'hBAD0_0000;

  always @(negedge f_clk) begin
    if (f_rst && f_o_valid && f_i_ready) begin
      n_pop++;
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pop_unexpected: got pc=%h instr=%h, expected no output", f_o_pc, f_o_instr);
      end else begin
        e_pc = exp_q.pop_front();
        if (f_o_pc !== e_pc || f_o_instr !== 32'h1000_0000 + e_pc || f_o_pc_plus4 !== e_pc + 32'd4) begin
          n_fail++;
          $display("FAIL pop_data: got pc=%h instr=%h pc4=%h, expected pc=%h instr=%h pc4=%h",
                   f_o_pc, f_o_instr, f_o_pc_plus4, e_pc, 32'h1000_0000 + e_pc, e_pc + 32'd4);
        end
      end
    end
  end

  task automatic step();
    @(posedge f_clk);
    #1;
  endtask

  task automatic fill(input logic [31:0] s);
    exp_q.delete();
    for (int i = 0; i < 256; i++) exp_q.push_back(s + 32'(4 * i));
  endtask

  task automatic test_reset();
    f_i_ce = 1'b1;
    f_i_ready = 1'b1;
    f_rst = 1'b0;
    fill(RST_PC);
    repeat (2) step();
    @(negedge f_clk);
    n_chk++;
    if (f_o_imem_req !== 1'b0 || f_o_valid !== 1'b0 || f_o_imem_addr !== 32'h0 || f_o_instr !== 32'h0 ||
        f_o_pc !== 32'h0 || f_o_pc_plus4 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: req=%b valid=%b addr=%h instr=%h pc=%h pc4=%h, expected all 0",
               f_o_imem_req, f_o_valid, f_o_imem_addr, f_o_instr, f_o_pc, f_o_pc_plus4);
    end
    step();
    f_rst = 1'b1;
    @(negedge f_clk);
    n_chk++;
    if (f_o_imem_req !== 1'b1 || f_o_imem_addr !== RST_PC) begin
      n_fail++;
      $display("FAIL first_req: req=%b addr=%h, expected req=1 addr=%h", f_o_imem_req, f_o_imem_addr, RST_PC);
    end
    step();
    @(negedge f_clk);
    n_chk++;
    if (f_o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_k1: valid=%b, expected 0", f_o_valid);
    end
    step();
    @(negedge f_clk);
    n_chk++;
    if (f_o_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL latency_k2: valid=%b, expected 1", f_o_valid);
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 8; i++) begin
      step();
      @(negedge f_clk);
      n_chk++;
      if (f_o_valid !== 1'b1 || f_o_imem_req !== 1'b1) begin
        n_fail++;
        $display("FAIL stream_throughput[%0d]: valid=%b req=%b, expected 1 1", i, f_o_valid, f_o_imem_req);
      end
      if (i == 0) begin
        n_chk++;
        if (f_o_pc !== 32'hFFFF_FFFC || f_o_pc_plus4 !== 32'h0) begin
          n_fail++;
          $display("FAIL wrap_pc4: pc=%h pc4=%h, expected fffffffc 00000000", f_o_pc, f_o_pc_plus4);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    step();
    f_i_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      @(negedge f_clk);
      if (i == 0) begin
        h_pc = f_o_pc;
        h_in = f_o_instr;
      end else begin
        n_chk++;
        if (f_o_valid !== 1'b1 || f_o_pc !== h_pc || f_o_instr !== h_in || f_o_imem_req !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_hold[%0d]: valid=%b pc=%h instr=%h req=%b, expected 1 %h %h 0",
                   i, f_o_valid, f_o_pc, f_o_instr, f_o_imem_req, h_pc, h_in);
        end
      end
    end
    step();
    f_i_ready = 1'b1;
    repeat (6) step();
  endtask

  task automatic test_redirect();
    f_i_ready = 1'b0;
    repeat (2) step();
    f_i_redirect = 1'b1;
    f_i_redirect_pc = 32'h40;
    @(negedge f_clk);
    n_chk++;
    if (f_o_imem_req !== 1'b0 || f_o_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL redir_cycle: req=%b valid=%b, expected 0 1", f_o_imem_req, f_o_valid);
    end
    step();
    f_i_redirect = 1'b0;
    f_i_ready = 1'b1;
    fill(32'h40);
    @(negedge f_clk);
    n_chk++;
    if (f_o_valid !== 1'b0 || f_o_imem_req !== 1'b1 || f_o_imem_addr !== 32'h40) begin
      n_fail++;
      $display("FAIL redir_n1: valid=%b req=%b addr=%h, expected 0 1 00000040", f_o_valid, f_o_imem_req, f_o_imem_addr);
    end
    step();
    @(negedge f_clk);
    n_chk++;
    if (f_o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL redir_n2: valid=%b, expected 0", f_o_valid);
    end
    step();
    @(negedge f_clk);
    n_chk++;
    if (f_o_valid !== 1'b1 || f_o_pc !== 32'h40) begin
      n_fail++;
      $display("FAIL redir_n3: valid=%b pc=%h, expected 1 00000040", f_o_valid, f_o_pc);
    end
    step();
    @(negedge f_clk);
    n_chk++;
    if (f_o_valid !== 1'b1 || f_o_pc !== 32'h44) begin
      n_fail++;
      $display("FAIL redir_n4: valid=%b pc=%h, expected 1 00000044", f_o_valid, f_o_pc);
    end
  endtask

  task automatic test_simultaneous();
    step();
    f_i_redirect = 1'b1;
    f_i_redirect_pc = 32'h200;
    @(negedge f_clk);
    n_chk++;
    if (f_o_valid !== 1'b1 || f_o_imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_cycle: valid=%b req=%b, expected 1 0", f_o_valid, f_o_imem_req);
    end
    step();
    f_i_redirect = 1'b0;
    fill(32'h200);
    @(negedge f_clk);
    n_chk++;
    if (f_o_valid !== 1'b0 || f_o_imem_req !== 1'b1 || f_o_imem_addr !== 32'h200) begin
      n_fail++;
      $display("FAIL simul_n1: valid=%b req=%b addr=%h, expected 0 1 00000200", f_o_valid, f_o_imem_req, f_o_imem_addr);
    end
    step();
    @(negedge f_clk);
    n_chk++;
    if (f_o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_n2: valid=%b, expected 0", f_o_valid);
    end
    step();
    @(negedge f_clk);
    n_chk++;
    if (f_o_valid !== 1'b1 || f_o_pc !== 32'h200) begin
      n_fail++;
      $display("FAIL simul_n3: valid=%b pc=%h, expected 1 00000200", f_o_valid, f_o_pc);
    end
    repeat (3) step();
  endtask

  task automatic test_enable();
    step();
    f_i_ce = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      @(negedge f_clk);
      n_chk++;
      if (f_o_imem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL ce_req[%0d]: req=%b, expected 0", i, f_o_imem_req);
      end
      if (i == 0) h_addr = f_o_imem_addr;
      else begin
        n_chk++;
        if (f_o_imem_addr !== h_addr || f_o_valid !== (i == 1)) begin
          n_fail++;
          $display("FAIL ce_hold[%0d]: addr=%h valid=%b, expected %h %b", i, f_o_imem_addr, f_o_valid, h_addr, i == 1);
        end
      end
    end
    step();
    f_i_ce = 1'b1;
    @(negedge f_clk);
    n_chk++;
    if (f_o_imem_req !== 1'b1 || f_o_imem_addr !== h_addr) begin
      n_fail++;
      $display("FAIL ce_resume: req=%b addr=%h, expected 1 %h", f_o_imem_req, f_o_imem_addr, h_addr);
    end
    repeat (6) step();
  endtask

  task automatic test_reset_mid();
    step();
    #3;
    f_rst = 1'b0;
    #1;
    n_chk++;
    if (f_o_imem_req !== 1'b0 || f_o_valid !== 1'b0 || f_o_imem_addr !== 32'h0 || f_o_instr !== 32'h0 ||
        f_o_pc !== 32'h0 || f_o_pc_plus4 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: req=%b valid=%b addr=%h instr=%h pc=%h pc4=%h, expected all 0",
               f_o_imem_req, f_o_valid, f_o_imem_addr, f_o_instr, f_o_pc, f_o_pc_plus4);
    end
    fill(RST_PC);
    repeat (2) step();
    f_rst = 1'b1;
    @(negedge f_clk);
    n_chk++;
    if (f_o_imem_req !== 1'b1 || f_o_imem_addr !== RST_PC) begin
      n_fail++;
      $display("FAIL reset_mid_restart: req=%b addr=%h, expected 1 %h", f_o_imem_req, f_o_imem_addr, RST_PC);
    end
    repeat (2) step();
    @(negedge f_clk);
    n_chk++;
    if (f_o_valid !== 1'b1 || f_o_pc !== RST_PC) begin
      n_fail++;
      $display("FAIL reset_mid_first: valid=%b pc=%h, expected 1 %h", f_o_valid, f_o_pc, RST_PC);
    end
    repeat (8) step();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_simultaneous();
    test_enable();
    test_reset_mid();
    @(negedge f_clk);
    n_chk++;
    if (n_pop < 20) begin
      n_fail++;
      $display("FAIL pop_count: got %0d pops, expected at least 20", n_pop);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
